// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store engine. Decodes the instruction held in the MEM
// pipeline register, runs a valid/ready request to data memory, waits for the
// load response, and returns the extracted/extended load result (or the ALU
// result for non-memory instructions) to writeback.
//
// Parameters
//   ADDR_WIDTH    data-memory word-address width
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   inst          instruction in the MEM pipeline register
//   alu_out       effective byte address / ALU result
//   rs2_rdata     store source data
//   stall_in      external stall; holds the unit in DONE
//   dm_req_*      request channel (valid/ready, we, word addr, strobes, data)
//   dm_rsp_*      load response channel (valid, word)
//   wb_data       result to writeback
//   stall_req     hold upstream stages while a memory op is in flight
//   misalign      misaligned-access flag, visible in DONE
//
// Build option
//   MEM_MISALIGN_TRAP_EN  misaligned LH/LHU/SH/LW/SW skip the memory access
//                         and report misalign; otherwise misalign is tied 0
//                         and the access uses the normal lane rules.
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           inst,
   input  logic [31:0]           alu_out,
   input  logic [31:0]           rs2_rdata,
   input  logic                  stall_in,
   output logic                  dm_req_valid,
   input  logic                  dm_req_ready,
   output logic                  dm_we,
   output logic [ADDR_WIDTH-1:0] dm_addr,
   output logic [3:0]            dm_wstrb,
   output logic [31:0]           dm_wdata,
   input  logic                  dm_rsp_valid,
   input  logic [31:0]           dm_rdata,
   output logic [31:0]           wb_data,
   output logic                  stall_req,
   output logic                  misalign
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Request payload; captured while in IDLE so it stays stable in REQ/WAIT.
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [3:0]            wstrb;
      logic [31:0]           wdata;
      logic [2:0]            funct3;
      logic [1:0]            lane;
   } req_t;

   state_t      state, next_state;
   req_t        cur_req, req_q, act_req;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [1:0]  lane;
   logic        is_load, is_store, mem_op;
   logic        misaligned_c;
   logic        load_en, load_clr;
   logic [31:0] load_q;

   // Bits of the instruction/address this stage does not look at.
   logic unused_bits;
   assign unused_bits = ^{inst[31:15], inst[11:7], alu_out[31:ADDR_WIDTH+2]};

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign lane   = alu_out[1:0];

   // Opcode/funct3 decode; unsupported widths fall through as non-memory.
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      if (opcode == OPC_LOAD) begin
         case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
            default:                                is_load = 1'b0;
         endcase
      end
      if (opcode == OPC_STORE) begin
         case (funct3)
            3'b000, 3'b001, 3'b010: is_store = 1'b1;
            default:                is_store = 1'b0;
         endcase
      end
   end

   assign mem_op = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
   // Halfword needs a[0]=0, word needs a=00; byte is always aligned.
   assign misaligned_c = ((funct3[1:0] == 2'b01) && lane[0]) ||
                         ((funct3[1:0] == 2'b10) && (lane != 2'b00));
`else
   assign misaligned_c = 1'b0;
`endif

   // Build the request from the current pipeline-register contents.
   always_comb begin
      cur_req        = '0;
      cur_req.we     = is_store;
      cur_req.addr   = alu_out[ADDR_WIDTH+1:2];
      cur_req.funct3 = funct3;
      cur_req.lane   = lane;
      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               cur_req.wstrb = 4'b0001 << lane;
               cur_req.wdata = {4{rs2_rdata[7:0]}};
            end
            2'b01: begin
               cur_req.wstrb = lane[1] ? 4'b1100 : 4'b0011;
               cur_req.wdata = {2{rs2_rdata[15:0]}};
            end
            default: begin
               cur_req.wstrb = 4'b1111;
               cur_req.wdata = rs2_rdata;
            end
         endcase
      end
   end

   assign act_req = (state == S_IDLE) ? cur_req : req_q;

   // Select the addressed byte/halfword lane and extend to 32 bits.
   function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{a, 3'b000} +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  extract_load = {{24{b[7]}}, b};
         3'b100:  extract_load = {24'h0, b};
         3'b001:  extract_load = {{16{h[15]}}, h};
         3'b101:  extract_load = {16'h0, h};
         default: extract_load = rdata;
      endcase
   endfunction

   // State register plus captured request and load result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         req_q  <= '0;
         load_q <= 32'h0;
      end else begin
         state <= next_state;
         if (state == S_IDLE) begin
            req_q <= cur_req;
         end
         if (load_clr) begin
            load_q <= 32'h0;
         end else if (load_en) begin
            load_q <= extract_load(dm_rdata, req_q.funct3, req_q.lane);
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // Remember whether the op that sent us to DONE was a trapped misalign.
   logic mis_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_q <= 1'b0;
      end else if (state == S_IDLE) begin
         mis_q <= mem_op & misaligned_c;
      end
   end
   assign misalign = (state == S_DONE) & mis_q;
`else
   assign misalign = 1'b0;
`endif

   // Next-state and handshake control.
   always_comb begin
      next_state   = state;
      dm_req_valid = 1'b0;
      stall_req    = 1'b0;
      load_en      = 1'b0;
      load_clr     = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE: begin
               if (mem_op) begin
                  stall_req = 1'b1;
                  if (misaligned_c) begin
                     load_clr   = 1'b1;
                     next_state = S_DONE;
                  end else begin
                     dm_req_valid = 1'b1;
                     if (dm_req_ready) begin
                        load_clr   = is_store;
                        next_state = is_store ? S_DONE : S_WAIT;
                     end else begin
                        next_state = S_REQ;
                     end
                  end
               end
            end
            S_REQ: begin
               stall_req    = mem_op;
               dm_req_valid = 1'b1;
               if (dm_req_ready) begin
                  load_clr   = req_q.we;
                  next_state = req_q.we ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               stall_req = mem_op;
               if (dm_rsp_valid) begin
                  load_en    = 1'b1;
                  next_state = S_DONE;
               end
            end
            S_DONE: begin
               if (!stall_in) begin
                  next_state = S_IDLE;
               end
            end
            default: next_state = S_IDLE;
         endcase
      end
   end

   assign dm_we    = dm_req_valid & act_req.we;
   assign dm_addr  = act_req.addr;
   assign dm_wstrb = dm_req_valid ? act_req.wstrb : 4'b0000;
   assign dm_wdata = act_req.wdata;

   // Writeback: load register in DONE, ALU result for non-memory ops.
   always_comb begin
      if (state == S_DONE) begin
         wb_data = load_q;
      end else if (mem_op) begin
         wb_data = 32'h0;
      end else begin
         wb_data = alu_out;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed, self-checking bench: a vector table of single transactions with
// immediate ready/response, plus hand-written multi-cycle sequences (held
// request, delayed response, stall in DONE, reset mid-transaction, misalign).
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int unsigned AW = 15;
   localparam logic [6:0] OPC_L = 7'b0000011;
   localparam logic [6:0] OPC_S = 7'b0100011;
   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [1:0] KN = 2'd0;
   localparam logic [1:0] KL = 2'd1;
   localparam logic [1:0] KS = 2'd2;
   localparam int NV = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   inst, alu_out, rs2_rdata, dm_rdata;
   logic          stall_in, dm_req_ready, dm_rsp_valid;
   logic          dm_req_valid, dm_we, stall_req, misalign;
   logic [AW-1:0] dm_addr;
   logic [3:0]    dm_wstrb;
   logic [31:0]   dm_wdata, wb_data;

   int n_checks = 0;
   int n_fail   = 0;
   int stall_cnt;

   typedef struct packed {
      logic [1:0]    kind;
      logic [31:0]   inst;
      logic [31:0]   alu;
      logic [31:0]   rs2;
      logic [31:0]   rdata;
      logic [3:0]    wstrb;
      logic [31:0]   wdata;
      logic [31:0]   wb;
      logic [AW-1:0] addr;
   } vec_t;

   vec_t vt [NV];

   mem_access_unit #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst         (inst),
      .alu_out      (alu_out),
      .rs2_rdata    (rs2_rdata),
      .stall_in     (stall_in),
      .dm_req_valid (dm_req_valid),
      .dm_req_ready (dm_req_ready),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wstrb     (dm_wstrb),
      .dm_wdata     (dm_wdata),
      .dm_rsp_valid (dm_rsp_valid),
      .dm_rdata     (dm_rdata),
      .wb_data      (wb_data),
      .stall_req    (stall_req),
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
      return {17'h0, f3, 5'd5, opc};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // kind, inst, alu_out, rs2, rdata, wstrb, wdata, wb, addr
      vt[0]  = '{KL, mk(OPC_L, 3'b010), 32'h10, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h0, 32'hDEADBEEF, 15'd4};
      vt[1]  = '{KL, mk(OPC_L, 3'b000), 32'h03, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFFFF80, 15'd0};
      vt[2]  = '{KL, mk(OPC_L, 3'b100), 32'h03, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00000080, 15'd0};
      vt[3]  = '{KL, mk(OPC_L, 3'b001), 32'h06, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'hFFFF8011, 15'd1};
      vt[4]  = '{KL, mk(OPC_L, 3'b101), 32'h06, 32'h0, 32'h80112233, 4'b0000, 32'h0, 32'h00008011, 15'd1};
      vt[5]  = '{KL, mk(OPC_L, 3'b000), 32'h01, 32'h0, 32'h12345678, 4'b0000, 32'h0, 32'h00000056, 15'd0};
      vt[6]  = '{KL, mk(OPC_L, 3'b001), 32'h100, 32'h0, 32'h00007FFF, 4'b0000, 32'h0, 32'h00007FFF, 15'd64};
      vt[7]  = '{KS, mk(OPC_S, 3'b000), 32'h02, 32'h000000A5, 32'h0, 4'b0100, 32'hA5A5A5A5, 32'h0, 15'd0};
      vt[8]  = '{KS, mk(OPC_S, 3'b010), 32'h20, 32'hCAFEF00D, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0, 15'd8};
      vt[9]  = '{KS, mk(OPC_S, 3'b001), 32'h04, 32'h1234ABCD, 32'h0, 4'b0011, 32'hABCDABCD, 32'h0, 15'd1};
      vt[10] = '{KN, mk(OPC_R, 3'b000), 32'h55, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h55, 15'd0};
      vt[11] = '{KN, mk(OPC_L, 3'b011), 32'h77, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h77, 15'd0};
      vt[12] = '{KN, mk(OPC_S, 3'b100), 32'h88, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h88, 15'd0};

      // Reset with a load present: no request, no stall.
      rst = 1'b1; inst = mk(OPC_L, 3'b010); alu_out = 32'h10; rs2_rdata = 32'h0;
      dm_rdata = 32'h0; stall_in = 1'b0; dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(dm_req_valid), 32'h0);
      chk("rst_stall", 32'(stall_req), 32'h0);
      chk("rst_misalign", 32'(misalign), 32'h0);
      next_cycle();
      rst = 1'b0; inst = mk(OPC_R, 3'b000); alu_out = 32'h1;
      next_cycle();

      // Table of single transactions with immediate ready/response.
      for (int i = 0; i < NV; i++) begin
         inst = vt[i].inst; alu_out = vt[i].alu; rs2_rdata = vt[i].rs2;
         dm_req_ready = 1'b1; dm_rsp_valid = 1'b0; dm_rdata = 32'h0; stall_in = 1'b0;
         @(negedge clk);
         if (vt[i].kind == KN) begin
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'h0);
            chk($sformatf("v%0d_valid", i), 32'(dm_req_valid), 32'h0);
            chk($sformatf("v%0d_wb", i), wb_data, vt[i].wb);
            next_cycle();
         end else begin
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'h1);
            chk($sformatf("v%0d_valid", i), 32'(dm_req_valid), 32'h1);
            chk($sformatf("v%0d_we", i), 32'(dm_we), 32'(vt[i].kind == KS));
            chk($sformatf("v%0d_addr", i), 32'(dm_addr), 32'(vt[i].addr));
            chk($sformatf("v%0d_wstrb", i), 32'(dm_wstrb), 32'(vt[i].wstrb));
            if (vt[i].kind == KS)
               chk($sformatf("v%0d_wdata", i), dm_wdata, vt[i].wdata);
            next_cycle();
            if (vt[i].kind == KL) begin
               dm_rsp_valid = 1'b1; dm_rdata = vt[i].rdata;
               @(negedge clk);
               chk($sformatf("v%0d_wait_stall", i), 32'(stall_req), 32'h1);
               chk($sformatf("v%0d_wait_valid", i), 32'(dm_req_valid), 32'h0);
               next_cycle();
               dm_rsp_valid = 1'b0; dm_rdata = 32'h0;
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_stall", i), 32'(stall_req), 32'h0);
            chk($sformatf("v%0d_done_valid", i), 32'(dm_req_valid), 32'h0);
            chk($sformatf("v%0d_done_wb", i), wb_data, vt[i].wb);
            next_cycle();
         end
      end

      // SH held in REQ while ready is low for 3 cycles.
      inst = mk(OPC_S, 3'b001); alu_out = 32'h06; rs2_rdata = 32'h1234ABCD;
      dm_req_ready = 1'b0; stall_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) dm_req_ready = 1'b1;
         @(negedge clk);
         if (stall_req) stall_cnt++;
         chk($sformatf("sh_valid_c%0d", c), 32'(dm_req_valid), 32'h1);
         chk($sformatf("sh_we_c%0d", c), 32'(dm_we), 32'h1);
         chk($sformatf("sh_addr_c%0d", c), 32'(dm_addr), 32'h1);
         chk($sformatf("sh_wstrb_c%0d", c), 32'(dm_wstrb), 32'hC);
         chk($sformatf("sh_wdata_c%0d", c), dm_wdata, 32'hABCDABCD);
         next_cycle();
      end
      dm_req_ready = 1'b0;
      @(negedge clk);
      if (stall_req) stall_cnt++;
      chk("sh_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("sh_done_wb", wb_data, 32'h0);
      next_cycle();

      // LB: ready low one cycle, rsp_valid asserted early (ignored), then response.
      inst = mk(OPC_L, 3'b000); alu_out = 32'h01;
      dm_rsp_valid = 1'b1; dm_rdata = 32'h0000FF00;
      @(negedge clk);
      chk("lb_idle_stall", 32'(stall_req), 32'h1);
      next_cycle();
      dm_req_ready = 1'b1;
      @(negedge clk);
      chk("lb_req_stall", 32'(stall_req), 32'h1);
      chk("lb_req_valid", 32'(dm_req_valid), 32'h1);
      next_cycle();
      dm_req_ready = 1'b0; dm_rsp_valid = 1'b0;
      @(negedge clk);
      chk("lb_wait_stall", 32'(stall_req), 32'h1);
      next_cycle();
      dm_rsp_valid = 1'b1; dm_rdata = 32'h00007F00;
      next_cycle();
      // DONE held by stall_in; a stray response must not disturb the result.
      dm_rdata = 32'hFFFFFFFF; stall_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("hold_stall_c%0d", c), 32'(stall_req), 32'h0);
         chk($sformatf("hold_valid_c%0d", c), 32'(dm_req_valid), 32'h0);
         chk($sformatf("hold_wb_c%0d", c), wb_data, 32'h0000007F);
         next_cycle();
      end
      stall_in = 1'b0; dm_rsp_valid = 1'b0;
      next_cycle();
      inst = mk(OPC_R, 3'b000); alu_out = 32'h42;
      @(negedge clk);
      chk("after_hold_wb", wb_data, 32'h42);
      next_cycle();

      // Reset while in WAIT, then a late response.
      inst = mk(OPC_L, 3'b010); alu_out = 32'h10; dm_req_ready = 1'b1;
      next_cycle();
      rst = 1'b1; dm_req_ready = 1'b0;
      @(negedge clk);
      chk("rstw_stall", 32'(stall_req), 32'h0);
      chk("rstw_valid", 32'(dm_req_valid), 32'h0);
      next_cycle();
      rst = 1'b0; inst = mk(OPC_R, 3'b000); alu_out = 32'h99;
      dm_rsp_valid = 1'b1; dm_rdata = 32'h11111111;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk($sformatf("rstw_wb_c%0d", c), wb_data, 32'h99);
         chk($sformatf("rstw_idle_stall_c%0d", c), 32'(stall_req), 32'h0);
         next_cycle();
      end
      dm_rsp_valid = 1'b0;

      // Misaligned word load.
      inst = mk(OPC_L, 3'b010); alu_out = 32'h02; dm_req_ready = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
      @(negedge clk);
      chk("mis_valid", 32'(dm_req_valid), 32'h0);
      chk("mis_stall", 32'(stall_req), 32'h1);
      next_cycle();
      @(negedge clk);
      chk("mis_flag", 32'(misalign), 32'h1);
      chk("mis_wb", wb_data, 32'h0);
      chk("mis_done_stall", 32'(stall_req), 32'h0);
      next_cycle();
      inst = mk(OPC_R, 3'b000); alu_out = 32'h5;
      @(negedge clk);
      chk("mis_flag_clear", 32'(misalign), 32'h0);
      chk("mis_next_wb", wb_data, 32'h5);
      next_cycle();
`else
      @(negedge clk);
      chk("mis_valid", 32'(dm_req_valid), 32'h1);
      chk("mis_addr", 32'(dm_addr), 32'h0);
      chk("mis_flag", 32'(misalign), 32'h0);
      next_cycle();
      dm_rsp_valid = 1'b1; dm_rdata = 32'hA1B2C3D4;
      next_cycle();
      dm_rsp_valid = 1'b0;
      @(negedge clk);
      chk("mis_wb", wb_data, 32'hA1B2C3D4);
      chk("mis_done_flag", 32'(misalign), 32'h0);
      next_cycle();
      inst = mk(OPC_S, 3'b001); alu_out = 32'h03; rs2_rdata = 32'h0000BEEF;
      @(negedge clk);
      chk("mis_sh_wstrb", 32'(dm_wstrb), 32'hC);
      chk("mis_sh_wdata", dm_wdata, 32'hBEEFBEEF);
      next_cycle();
      dm_req_ready = 1'b0;
      next_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning data-memory word-address width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port inst  input  32  instruction held in the MEM pipeline register.
REQ-005 SHALL have port alu_out  input  32  effective byte address, or ALU result for non-memory instructions.
REQ-006 SHALL have port rs2_rdata  input  32  store source data.
REQ-007 SHALL have port stall_in  input  1  external pipeline stall; blocks leaving DONE.
REQ-008 SHALL have port dm_req_valid  output  1  data-memory request valid.
REQ-009 SHALL have port dm_req_ready  input  1  data-memory request accepted.
REQ-010 SHALL have ports dm_we  output  1  (1 = store); dm_addr  output  ADDR_WIDTH  (word address = alu_out[ADDR_WIDTH+1:2]).
REQ-011 SHALL have ports dm_wstrb  output  4  byte-write strobes; dm_wdata  output  32  lane-replicated store data.
REQ-012 SHALL have ports dm_rsp_valid  input  1  (load data valid); dm_rdata  input  32  (load word).
REQ-013 SHALL have ports wb_data  output  32  (result to writeback); stall_req  output  1  (hold upstream stages); misalign  output  1  (misaligned-access flag).

Function
REQ-014 SHALL decode opcode 0000011 as load and 0100011 as store; funct3 0/1/2/4/5 = B/H/W/BU/HU for loads, 0/1/2 = B/H/W for stores; any other opcode or funct3 is a non-memory instruction.
REQ-015 SHALL, for non-memory instructions, drive wb_data = alu_out combinationally, with stall_req = 0 and dm_req_valid = 0 (zero latency).
REQ-016 SHALL implement the FSM IDLE, REQ, WAIT, DONE.
REQ-017 SHALL assert dm_req_valid in IDLE while a memory op is present, and in REQ.
- Handshake (valid and ready) on a load -> WAIT.
- Handshake on a store -> DONE.
- No handshake -> REQ.
REQ-018 SHALL hold dm_req_valid, dm_we, dm_addr, dm_wstrb and dm_wdata stable in REQ until dm_req_ready is 1.
REQ-019 SHALL, in WAIT, on dm_rsp_valid = 1, register the extracted load result into the load register and go to DONE.
REQ-020 SHALL, in DONE, deassert stall_req and drive wb_data from the load register (0 for stores); go to IDLE when stall_in = 0, otherwise remain in DONE with no new request issued.
REQ-021 SHALL drive stall_req = 1 whenever a memory op is present and state is not DONE.
REQ-022 SHALL give minimum latency (ready and rsp_valid immediate): store stall 1 cycle, load stall 2 cycles.
REQ-023 SHALL ignore dm_rsp_valid in IDLE, REQ and DONE.
REQ-024 SHALL generate store strobes and data from a = alu_out[1:0]:
- SB: wstrb = 0001<<a, wdata = {4{rs2[7:0]}}.
- SH: wstrb = 0011<<(2*a[1]), wdata = {2{rs2[15:0]}}.
- SW: wstrb = 1111, wdata = rs2.
REQ-025 SHALL extract load data from dm_rdata at byte lane a (halfword lane a[1], word unshifted), then sign-extend (B, H) or zero-extend (BU, HU).
REQ-026 SHALL drive dm_wstrb = 0000 and dm_we = 0 for loads.

Reset
REQ-027 SHALL, while rst = 1, force state = IDLE, load register = 0, and dm_req_valid, stall_req and misalign = 0.
REQ-028 SHALL, on reset mid-operation, abandon the transaction; a late dm_rsp_valid after reset is ignored.

Configuration
REQ-029 SHALL, with macro MEM_MISALIGN_TRAP_EN defined, treat LH/LHU/SH with a[0] = 1 and LW/SW with a != 0 as misaligned:
- No request is issued.
- FSM goes IDLE -> DONE directly.
- misalign = 1 during DONE; wb_data = 0.
REQ-030 SHALL, without MEM_MISALIGN_TRAP_EN, tie misalign to 0 and perform the access using the lane rules of REQ-024/025, ignoring the offending low address bits.

Verification
REQ-031 SHALL cover: LW alu_out=0x10, ready=1, rsp next cycle with rdata=0xDEADBEEF -> dm_addr=4, stall 2 cycles, wb_data=0xDEADBEEF in DONE.
REQ-032 SHALL cover: LB alu_out=0x03, rdata=0x80112233 -> wb_data=0xFFFFFF80; same access with LBU -> 0x00000080.
REQ-033 SHALL cover: SH alu_out=0x06, rs2=0x1234ABCD, ready low 3 cycles -> request held stable 4 cycles, wstrb=1100, wdata=0xABCDABCD, stall 4 cycles.
REQ-034 SHALL cover: ADD with alu_out=0x55 -> wb_data=0x55 same cycle, stall_req=0, no request issued.
REQ-035 SHALL cover: rst pulse while in WAIT, then rsp_valid -> state IDLE, wb_data unaffected, no DONE.
REQ-036 SHALL cover: with MEM_MISALIGN_TRAP_EN, LW alu_out=0x02 -> no request, misalign=1 for one cycle, wb_data=0.
